// File: rtl/core_data_arb_pkg.sv
// Shared types for the core data-port arbiter.
package core_data_arb_pkg;

    localparam int NUM_PORTS  = 2;
    // Struct field widths; the top's ADDR_WIDTH is cast onto ARB_ADDR_W.
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef logic port_id_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  we;
        logic [3:0]            be;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/core_data_arb_owner_fifo.sv
// In-order FIFO of transaction owners (granted, awaiting rvalid).
module core_data_arb_owner_fifo
    import core_data_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  port_id_t push_id_i,
    input  logic     pop_i,
    output port_id_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    port_id_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    // Power-of-two depth lets the pointers wrap naturally; depth 1 pins them at 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (DEPTH == 1) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= push_id_i;
    end

    // Pointer and occupancy update; simultaneous push/pop keeps count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/core_data_arb.sv
// Two-port arbiter in front of the bridge data port. Owner FIFO routes rvalid.
// Build option: CORE_DATA_ARB_RR_EN selects round-robin tie-break (else port 0 wins).
module core_data_arb
    import core_data_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic [31:0]           m0_rdata_o,
    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic [31:0]           m1_rdata_o,
    output logic                  s_req_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    output logic [31:0]           s_wdata_o,
    input  logic [31:0]           s_rdata_i,
    output logic                  err_o
);

    arb_req_t               req_f [NUM_PORTS];
    arb_req_t               win_f;
    logic [NUM_PORTS-1:0]   req;
    logic                   win_vld;
    port_id_t               win_id;
    port_id_t               tie_id;
    logic                   lock_q;
    port_id_t               lock_id_q;
    logic                   lock_hold;
    logic                   hs;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    port_id_t               head;

    assign req      = {m1_req_i, m0_req_i};
    assign req_f[0] = '{addr: ARB_ADDR_W'(m0_addr_i), we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign req_f[1] = '{addr: ARB_ADDR_W'(m1_addr_i), we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

`ifdef CORE_DATA_ARB_RR_EN
    port_id_t last_q;

    // Remember the last granted port; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i)   last_q <= 1'b1;
        else if (hs) last_q <= win_id;
    end

    assign tie_id = ~last_q;
`else
    assign tie_id = 1'b0;
`endif

    // A lock only survives while the locked port keeps requesting.
    assign lock_hold = lock_q && req[lock_id_q];

    // Winner select: lock first, else arbitrate only when the FIFO has room.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 1'b0;
        if (lock_hold) begin
            win_vld = 1'b1;
            win_id  = lock_id_q;
        end else if (!fifo_full) begin
            win_vld = |req;
            win_id  = (&req) ? tie_id : req[1];
        end
    end

    assign win_f     = win_vld ? req_f[win_id] : '0;
    assign s_req_o   = win_vld;
    assign s_addr_o  = ADDR_WIDTH'(win_f.addr);
    assign s_we_o    = win_f.we;
    assign s_be_o    = win_f.be;
    assign s_wdata_o = win_f.wdata;

    assign hs       = s_req_o && s_gnt_i;
    assign m0_gnt_o = hs && (win_id == 1'b0);
    assign m1_gnt_o = hs && (win_id == 1'b1);

    // Hold the stalled winner until its grant (or until it withdraws).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else if (s_req_o && !s_gnt_i) begin
            lock_q    <= 1'b1;
            lock_id_q <= win_id;
        end else begin
            lock_q    <= 1'b0;
        end
    end

    core_data_arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (hs),
        .push_id_i (win_id),
        .pop_i     (pop),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign pop         = s_rvalid_i && !fifo_empty;
    assign m0_rvalid_o = pop && (head == 1'b0);
    assign m1_rvalid_o = pop && (head == 1'b1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    // Sticky: a response with no recorded owner.
    always_ff @(posedge clk_i) begin
        if (rst_i)                         err_o <= 1'b0;
        else if (s_rvalid_i && fifo_empty) err_o <= 1'b1;
    end

endmodule

// File: tb/tb_core_data_arb.sv
// Scoreboard bench for core_data_arb: stimulus pushes expected grants and
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_core_data_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_we, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic        s_req, s_gnt, s_rvalid, s_we, err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    typedef struct {
        logic        id;
        logic [31:0] val;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    core_data_arb #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
        .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .err_o(err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
        m0_addr = '0; m1_addr = '0; m0_we = 0; m1_we = 0;
        m0_be = 4'hf; m1_be = 4'hf; m0_wdata = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_s_req", {31'b0, s_req}, 32'd0);
        chk("rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
    endtask

    function automatic void exp_gnt(input logic id, input logic [31:0] addr);
        gq.push_back('{id: id, val: addr});
    endfunction

    function automatic void exp_rsp(input logic id, input logic [31:0] data);
        rq.push_back('{id: id, val: data});
    endfunction

    // Monitor: every handshake and every routed response is matched in order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (s_req && s_gnt) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", {30'b0, m1_gnt, m0_gnt}, 32'd0);
                end else begin
                    e = gq.pop_front();
                    chk("grant_port", {30'b0, m1_gnt, m0_gnt}, e.id ? 32'd2 : 32'd1);
                    chk("grant_addr", s_addr, e.val);
                end
            end else begin
                if (m0_gnt || m1_gnt) chk("grant_no_hs", {30'b0, m1_gnt, m0_gnt}, 32'd0);
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rvalid_port", {30'b0, m1_rvalid, m0_rvalid}, e.id ? 32'd2 : 32'd1);
                    chk("rdata", e.id ? m1_rdata : m0_rdata, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_id [4];
        rst = 1'b1;
        idle();
        @(negedge clk);
        do_reset();

        // Single read from port 0, response two cycles after the grant.
        m0_req = 1; m0_addr = 32'h1000; s_gnt = 1;
        exp_gnt(0, 32'h1000);
        #1 chk("t1_gnt_same_cycle", {31'b0, m0_gnt}, 32'd1);
        tick(); idle(); tick();
        s_rvalid = 1; s_rdata = 32'hDEADBEEF;
        exp_rsp(0, 32'hDEADBEEF);
        #1 chk("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        tick(); idle();

        // Both ports request every cycle; one response drains per cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef CORE_DATA_ARB_RR_EN
            exp_id[i] = i[0];
`else
            exp_id[i] = 1'b0;
`endif
            m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_gnt = 1;
            exp_gnt(exp_id[i], exp_id[i] ? 32'h200 : 32'h100);
            s_rvalid = (i > 0); s_rdata = 32'h50 + i;
            if (i > 0) exp_rsp(exp_id[i-1], 32'h50 + i);
            tick();
        end
        idle(); s_rvalid = 1; s_rdata = 32'h54;
        exp_rsp(exp_id[3], 32'h54);
        tick(); idle();

        // Port 1 stalls 3 cycles; port 0 joins but the lock holds port 1.
        do_reset();
        m1_req = 1; m1_addr = 32'h300; m1_wdata = 32'hCAFE0001; m1_we = 1;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) begin m0_req = 1; m0_addr = 32'h400; end
            #1;
            chk("t3_s_req", {31'b0, s_req}, 32'd1);
            chk("t3_s_addr", s_addr, 32'h300);
            chk("t3_s_wdata", s_wdata, 32'hCAFE0001);
            tick();
        end
        s_gnt = 1; exp_gnt(1, 32'h300);
        tick();
        m1_req = 0; exp_gnt(0, 32'h400);
        tick();
        idle(); s_rvalid = 1; s_rdata = 32'h31; exp_rsp(1, 32'h31);
        tick();
        s_rdata = 32'h40; exp_rsp(0, 32'h40);
        tick(); idle();

        // FIFO full blocks the third request until the cycle after a pop.
        do_reset();
        m0_req = 1; m0_addr = 32'h10; s_gnt = 1; exp_gnt(0, 32'h10);
        tick();
        m0_req = 0; m1_req = 1; m1_addr = 32'h20; exp_gnt(1, 32'h20);
        tick();
        m1_req = 0; m0_req = 1; m0_addr = 32'h30;
        #1 chk("t4_full_s_req", {31'b0, s_req}, 32'd0);
        tick();
        s_rvalid = 1; s_rdata = 32'hA; exp_rsp(0, 32'hA);
        #1 chk("t4_no_bypass", {31'b0, s_req}, 32'd0);
        tick();
        s_rdata = 32'hB; exp_rsp(1, 32'hB); exp_gnt(0, 32'h30);
        #1 chk("t4_after_pop", {31'b0, s_req}, 32'd1);
        tick();
        m0_req = 0; s_gnt = 0; s_rdata = 32'hC; exp_rsp(0, 32'hC);
        tick(); idle();

        // Response with nothing outstanding: dropped and sticky error.
        chk("t5_err_before", {31'b0, err}, 32'd0);
        s_rvalid = 1; s_rdata = 32'h77;
        #1 chk("t5_no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        tick(); idle();
        chk("t5_err_set", {31'b0, err}, 32'd1);
        repeat (3) tick();
        chk("t5_err_sticky", {31'b0, err}, 32'd1);

        // Reset with two transactions in flight.
        do_reset();
        m0_req = 1; m0_addr = 32'h500; s_gnt = 1; exp_gnt(0, 32'h500);
        tick();
        m0_req = 0; m1_req = 1; m1_addr = 32'h600; exp_gnt(1, 32'h600);
        tick();
        idle(); rst = 1;
        tick();
        rst = 0;
        s_rvalid = 1; s_rdata = 32'h99;
        #1 chk("t6_stale_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        tick(); idle();
        chk("t6_err", {31'b0, err}, 32'd1);
        m0_req = 1; m0_addr = 32'h700; s_gnt = 1; exp_gnt(0, 32'h700);
        #1 chk("t6_new_gnt", {31'b0, m0_gnt}, 32'd1);
        tick(); idle();
        repeat (2) tick();

        chk("grant_queue_drained", gq.size(), 32'd0);
        chk("rsp_queue_drained", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
